// File: rtl/npc_bp.sv
// Next-PC unit: owns the fetch PC, predicts with a direct-mapped BTB + 2-bit
// counters, and resolves the ID instruction to flush/redirect on a mispredict.
module npc_bp #(
    parameter int                 ADDR_W    = 32,
    parameter int                 BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 'h3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              res_valid,
    input  logic              res_br,
    input  logic              cmp_out,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              jump,
    input  logic [25:0]       imm26,
    input  logic              ji,
    input  logic [ADDR_W-1:0] ji_addr,
    input  logic [ADDR_W-1:0] ext_imm,
    output logic [ADDR_W-1:0] pc,
    output logic              pred_taken,
    output logic              flush
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ADDR_W-1:0]    r_pc, r_id_pc, r_id_pred;
    logic                 r_id_ok;
    logic [BTB_DEPTH-1:0] r_vld;
    logic [TAG_W-1:0]     r_tag [BTB_DEPTH];
    logic [ADDR_W-1:0]    r_tgt [BTB_DEPTH];
    logic [1:0]           r_ctr [BTB_DEPTH];

    // Fetch-side lookup
    logic [IDX_W-1:0]  w_f_idx;
    logic [TAG_W-1:0]  w_f_tag;
    logic              w_f_hit;
    logic [ADDR_W-1:0] w_pred_next;

    assign w_f_idx     = r_pc[IDX_W+1:2];
    assign w_f_tag     = r_pc[ADDR_W-1:IDX_W+2];
    assign w_f_hit     = r_vld[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
    assign w_pred_next = pred_taken ? r_tgt[w_f_idx] : r_pc + ADDR_W'(4);
    assign pc          = r_pc;

    // ID-side resolution
    logic [ADDR_W-1:0] w_id_inc, w_br_tgt, w_jmp_tgt, w_ji_tgt, w_actual;
    logic              w_act, w_br_tk, w_taken, w_cond, w_ntc;

    assign w_id_inc  = r_id_pc + ADDR_W'(4);
    assign w_br_tgt  = w_id_inc + (ext_imm << 2);
    assign w_jmp_tgt = {{(ADDR_W-28){1'b0}}, imm26, 2'b00};
    assign w_ji_tgt  = ji_addr + ext_imm;

    always_comb begin
        w_actual = w_id_inc;
        if (jr)          w_actual = jr_addr;
        else if (jump)   w_actual = w_jmp_tgt;
        else if (w_br_tk) w_actual = w_br_tgt;
        else if (ji)     w_actual = w_ji_tgt;
    end

    assign w_act   = res_valid && r_id_ok && !stall;
    assign flush   = w_act && (w_actual != r_id_pred);
    assign w_br_tk = res_br && cmp_out;
    assign w_taken = jr || jump || ji || w_br_tk;
    // A taken branch is only "conditional" when no unconditional source outranks it
    assign w_cond  = w_br_tk && !jr && !jump;
    assign w_ntc   = res_br && !w_taken;

    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [1:0]       w_u_ctr;

    assign w_u_idx = r_id_pc[IDX_W+1:2];
    assign w_u_tag = r_id_pc[ADDR_W-1:IDX_W+2];
    assign w_u_hit = r_vld[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_ctr = r_ctr[w_u_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_id_ok <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                r_pc    <= w_actual;
                r_id_ok <= 1'b0;
            end else begin
                r_pc      <= w_pred_next;
                r_id_pc   <= r_pc;
                r_id_pred <= w_pred_next;
                r_id_ok   <= 1'b1;
            end
        end
    end

    // BTB write happens on the edge, so a same-index lookup this cycle sees old data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_act) begin
            if (w_taken) begin
                r_tgt[w_u_idx] <= w_actual;
                if (w_u_hit) begin
                    r_ctr[w_u_idx] <= (w_u_ctr == 2'b11) ? 2'b11 : w_u_ctr + 2'd1;
                end else begin
                    r_vld[w_u_idx] <= 1'b1;
                    r_tag[w_u_idx] <= w_u_tag;
                    r_ctr[w_u_idx] <= w_cond ? 2'b10 : 2'b11;
                end
            end else if (w_ntc && w_u_hit) begin
                r_ctr[w_u_idx] <= (w_u_ctr == 2'b00) ? 2'b00 : w_u_ctr - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_npc_bp.sv
// Directed bench for npc_bp: per-cycle vector table plus short hand-written
// sequences for wrap-around redirects.
module tb_npc_bp;
    logic        clk, rst, stall, res_valid, res_br, cmp_out, jr, jump, ji;
    logic [31:0] jr_addr, ji_addr, ext_imm, pc;
    logic [25:0] imm26;
    logic        pred_taken, flush;

    npc_bp dut (
        .clk(clk), .rst(rst), .stall(stall), .res_valid(res_valid),
        .res_br(res_br), .cmp_out(cmp_out), .jr(jr), .jr_addr(jr_addr),
        .jump(jump), .imm26(imm26), .ji(ji), .ji_addr(ji_addr),
        .ext_imm(ext_imm), .pc(pc), .pred_taken(pred_taken), .flush(flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctl = {br, cmp, jr, jump, ji}
    localparam logic [4:0] NC = 5'b00000, BT = 5'b11000, BN = 5'b10000;
    localparam logic [4:0] JR = 5'b00100, JP = 5'b00010, JI = 5'b00001, PRI = 5'b11110;

    typedef struct {
        bit          rst, stall, vld;
        logic [4:0]  ctl;
        logic [31:0] a;
        logic [25:0] imm;
        logic [31:0] b, ext;
        bit          chk;
        logic [31:0] e_pc;
        bit          e_pt, e_fl;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(bit r, bit s, bit v, logic [4:0] c, logic [31:0] a,
                                logic [25:0] imm, logic [31:0] b, logic [31:0] ext,
                                bit chk, logic [31:0] epc, bit ept, bit efl);
        vec_t t;
        t.rst = r; t.stall = s; t.vld = v; t.ctl = c; t.a = a; t.imm = imm;
        t.b = b; t.ext = ext; t.chk = chk; t.e_pc = epc; t.e_pt = ept; t.e_fl = efl;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst = t.rst; stall = t.stall; res_valid = t.vld;
        {res_br, cmp_out, jr, jump, ji} = t.ctl;
        jr_addr = t.a; imm26 = t.imm; ji_addr = t.b; ext_imm = t.ext;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t t);
        check({tag, "_pc"}, pc, t.e_pc);
        check({tag, "_pred_taken"}, {31'b0, pred_taken}, {31'b0, t.e_pt});
        check({tag, "_flush"}, {31'b0, flush}, {31'b0, t.e_fl});
    endtask

    initial begin
        vec_t h;
        drive(mk(1, 0, 0, NC, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset, sequential fetch, reset again
        tv.push_back(mk(1, 0, 0, NC, 0, 0, 0, 0, 0, 32'h0,    0, 0));
        tv.push_back(mk(1, 0, 0, NC, 0, 0, 0, 0, 0, 32'h0,    0, 0));
        tv.push_back(mk(0, 0, 0, NC, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3004, 0, 0));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3008, 0, 0));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h300C, 0, 0));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3010, 0, 0));
        tv.push_back(mk(1, 0, 0, NC, 0, 0, 0, 0, 1, 32'h3014, 0, 0));
        tv.push_back(mk(1, 0, 0, NC, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        // cold taken beq at 0x3008 -> 0x301C, jump at 0x301C back to 0x3008
        tv.push_back(mk(0, 0, 0, NC, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3004, 0, 0));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3008, 0, 0));
        tv.push_back(mk(0, 0, 1, BT, 0, 0, 0, 4, 1, 32'h300C, 0, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h301C, 0, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC02, 0, 0, 1, 32'h3020, 0, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3008, 1, 0));
        // hysteresis: 10 -> 01 (flush), 01 -> 00 (no flush), saturate at 00
        tv.push_back(mk(0, 0, 1, BN, 0, 0, 0, 4, 1, 32'h301C, 1, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h300C, 0, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC02, 0, 0, 1, 32'h3010, 0, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3008, 0, 0));
        tv.push_back(mk(0, 0, 1, BN, 0, 0, 0, 4, 1, 32'h300C, 1, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC02, 0, 0, 1, 32'h3008, 0, 0));
        tv.push_back(mk(0, 0, 1, BN, 0, 0, 0, 4, 1, 32'h300C, 1, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC02, 0, 0, 1, 32'h3008, 0, 0));
        // ji base+imm to 0x4000, then jr/jump/branch together at fresh pc 0x4000
        tv.push_back(mk(0, 0, 1, JI, 0, 0, 32'h3F00, 32'h100, 1, 32'h300C, 1, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h4000, 0, 0));
        tv.push_back(mk(0, 0, 1, PRI, 32'h4000, 26'hC02, 0, 4, 1, 32'h4004, 0, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h4000, 1, 0));
        tv.push_back(mk(0, 0, 1, JR, 32'h4000, 0, 0, 0, 1, 32'h4000, 1, 0));
        // stall over a mispredicting jump, then release
        tv.push_back(mk(0, 1, 1, JP, 0, 26'hC00, 0, 0, 1, 32'h4000, 1, 0));
        tv.push_back(mk(0, 1, 1, JP, 0, 26'hC00, 0, 0, 1, 32'h4000, 1, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC00, 0, 0, 1, 32'h4000, 1, 1));
        // 0x3000 <-> 0x3040 alias on index 0
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC10, 0, 0, 1, 32'h3004, 0, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3040, 0, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC00, 0, 0, 1, 32'h3044, 0, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        tv.push_back(mk(0, 0, 1, JP, 0, 26'hC10, 0, 0, 1, 32'h3004, 0, 1));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3040, 0, 0));
        // reset on a flush cycle; trained 0x3000 must miss afterwards
        tv.push_back(mk(1, 0, 1, JP, 0, 26'hC00, 0, 0, 1, 32'h3044, 0, 1));
        tv.push_back(mk(0, 0, 0, NC, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        tv.push_back(mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h3004, 0, 0));

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            if (tv[i].chk) check_all($sformatf("v%0d", i), tv[i]);
        end

        // ji sum wraps past 2^32: 0xFFFFFFF0 + 0x14 = 0x4
        @(negedge clk);
        h = mk(0, 0, 1, JI, 0, 0, 32'hFFFF_FFF0, 32'h14, 1, 32'h3008, 0, 1);
        drive(h); #1; check_all("wrap_ji", h);
        @(negedge clk);
        h = mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h4, 0, 0);
        drive(h); #1; check_all("wrap_ji_pc", h);
        // backward branch from 0x4: 0x8 + (-2<<2) = 0x0
        @(negedge clk);
        h = mk(0, 0, 1, BT, 0, 0, 0, 32'hFFFF_FFFE, 1, 32'h8, 0, 1);
        drive(h); #1; check_all("wrap_br", h);
        @(negedge clk);
        h = mk(0, 0, 1, NC, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        drive(h); #1; check_all("wrap_br_pc", h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
